// File: rtl/rr_mux_arb_pkg.sv
// Shared arbiter state type, parameter limits and pointer helper for rr_mux_arb.
package rr_mux_arb_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  localparam int SIZE_MIN     = 2;
  localparam int SIZE_MAX     = 16;
  localparam int PIPELINE_MIN = 0;
  localparam int PIPELINE_MAX = 4;

  function automatic int next_idx(input int idx, input int size);
    return (idx + 1 >= size) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_mux_arb_pick.sv
// Rotate-priority pick: first set req_valid bit at or after ptr, wrapping to 0.
// Purely combinational, no backpressure of its own.
module rr_pick
  import rr_mux_arb_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int WIDTHS = 2
) (
  input  logic [WIDTHS-1:0] ptr,
  input  logic [SIZE-1:0]   req_valid,
  output logic [WIDTHS-1:0] winner,
  output logic              found
);

  logic [WIDTHS-1:0] win_hi;
  logic [WIDTHS-1:0] win_lo;
  logic              found_hi;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    win_hi   = '0;
    win_lo   = '0;
    found_hi = 1'b0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        win_lo = WIDTHS'(i);
      end
      if (req_valid[i] && (i >= int'(ptr))) begin
        win_hi   = WIDTHS'(i);
        found_hi = 1'b1;
      end
    end
  end

  assign winner = found_hi ? win_hi : win_lo;
  assign found  = |req_valid;

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin N:1 mux arbiter; PIPELINE register stages (0 = combinational), stalls when out_valid && !out_ready.
// Define RR_MUX_ARB_LOCK_EN to add req_last and hold the grant across a burst (ARB/LOCK FSM).
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = 4,
  parameter int WIDTHS   = 2,
  parameter int PIPELINE = 1
) (
  input  logic                    clock,
  input  logic                    sclr,
  input  logic                    clken,
  input  logic [SIZE-1:0]         req_valid,
  input  logic [SIZE*WIDTH-1:0]   req_data,
`ifdef RR_MUX_ARB_LOCK_EN
  input  logic [SIZE-1:0]         req_last,
`endif
  output logic [SIZE-1:0]         req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [WIDTHS-1:0]       out_sel
);

  logic [WIDTH-1:0]  req_word [SIZE];
  logic [WIDTHS-1:0] ptr;
  logic [WIDTHS-1:0] winner;
  logic [SIZE-1:0]   cand;
  logic              found;
  logic              adv;
  logic              grant;
  logic              ptr_step;

  for (genvar g = 0; g < SIZE; g++) begin : g_word
    assign req_word[g] = req_data[g*WIDTH +: WIDTH];
  end

`ifdef RR_MUX_ARB_LOCK_EN
  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [WIDTHS-1:0] lock_idx;

  // While locked only the burst owner is a candidate.
  assign cand = (state == LOCK) ? (req_valid & (SIZE'(1) << lock_idx)) : req_valid;

  always_ff @(posedge clock) begin
    if (sclr) begin
      state    <= ARB;
      lock_idx <= '0;
    end else begin
      state <= state_nxt;
      if (grant && (state == ARB)) begin
        lock_idx <= winner;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_step  = 1'b0;
    case (state)
      ARB: begin
        if (grant) begin
          if (req_last[winner]) begin
            ptr_step = 1'b1;
          end else begin
            state_nxt = LOCK;
          end
        end
      end
      LOCK: begin
        if (grant && req_last[winner]) begin
          ptr_step  = 1'b1;
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end
`else
  assign cand     = req_valid;
  assign ptr_step = grant;
`endif

  rr_pick #(
    .SIZE   (SIZE),
    .WIDTHS (WIDTHS)
  ) u_pick (
    .ptr       (ptr),
    .req_valid (cand),
    .winner    (winner),
    .found     (found)
  );

  assign adv       = clken && !(out_valid && !out_ready);
  assign grant     = found && adv && !sclr;
  assign req_ready = grant ? (SIZE'(1) << winner) : '0;

  always_ff @(posedge clock) begin
    if (sclr) begin
      ptr <= '0;
    end else if (ptr_step) begin
      ptr <= WIDTHS'(next_idx(int'(winner), SIZE));
    end
  end

  if (PIPELINE == 0) begin : g_comb
    assign out_valid = found;
    assign out_data  = found ? req_word[winner] : '0;
    assign out_sel   = found ? winner : '0;
  end else begin : g_pipe
    logic [PIPELINE-1:0] stg_vld;
    logic [WIDTH-1:0]    stg_dat [PIPELINE];
    logic [WIDTHS-1:0]   stg_sel [PIPELINE];

    // Bubbles carry zero payload so out_data/out_sel read 0 whenever out_valid is low.
    always_ff @(posedge clock) begin
      if (sclr) begin
        stg_vld <= '0;
        for (int s = 0; s < PIPELINE; s++) begin
          stg_dat[s] <= '0;
          stg_sel[s] <= '0;
        end
      end else if (adv) begin
        stg_vld[0] <= grant;
        stg_dat[0] <= grant ? req_word[winner] : '0;
        stg_sel[0] <= grant ? winner : '0;
        for (int s = 1; s < PIPELINE; s++) begin
          stg_vld[s] <= stg_vld[s-1];
          stg_dat[s] <= stg_dat[s-1];
          stg_sel[s] <= stg_sel[s-1];
        end
      end
    end

    assign out_valid = stg_vld[PIPELINE-1];
    assign out_data  = stg_dat[PIPELINE-1];
    assign out_sel   = stg_sel[PIPELINE-1];
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench: instance a (PIPELINE=1) for rotation, stall, clken and lock; instance b (PIPELINE=2) for latency and clear.
module tb_rr_mux_arb;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int WS = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            a_sclr, a_clken, a_out_ready, a_out_valid;
  logic [N-1:0]    a_req_valid, a_req_ready;
  logic [N*W-1:0]  a_req_data;
  logic [W-1:0]    a_out_data;
  logic [WS-1:0]   a_out_sel;

  logic            b_sclr, b_clken, b_out_ready, b_out_valid;
  logic [N-1:0]    b_req_valid, b_req_ready;
  logic [N*W-1:0]  b_req_data;
  logic [W-1:0]    b_out_data;
  logic [WS-1:0]   b_out_sel;

`ifdef RR_MUX_ARB_LOCK_EN
  logic [N-1:0]    a_req_last, b_req_last;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  rr_mux_arb #(.WIDTH(W), .SIZE(N), .WIDTHS(WS), .PIPELINE(1)) u_a (
    .clock     (clock),
    .sclr      (a_sclr),
    .clken     (a_clken),
    .req_valid (a_req_valid),
    .req_data  (a_req_data),
`ifdef RR_MUX_ARB_LOCK_EN
    .req_last  (a_req_last),
`endif
    .req_ready (a_req_ready),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel)
  );

  rr_mux_arb #(.WIDTH(W), .SIZE(N), .WIDTHS(WS), .PIPELINE(2)) u_b (
    .clock     (clock),
    .sclr      (b_sclr),
    .clken     (b_clken),
    .req_valid (b_req_valid),
    .req_data  (b_req_data),
`ifdef RR_MUX_ARB_LOCK_EN
    .req_last  (b_req_last),
`endif
    .req_ready (b_req_ready),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic vld, input logic [WS-1:0] sel, input logic [W-1:0] dat);
    chk({tag, ".out_valid"}, 64'(a_out_valid), 64'(vld));
    chk({tag, ".out_sel"},   64'(a_out_sel),   64'(sel));
    chk({tag, ".out_data"},  64'(a_out_data),  64'(dat));
  endtask

  task automatic chk_b(input string tag, input logic vld, input logic [WS-1:0] sel, input logic [W-1:0] dat);
    chk({tag, ".out_valid"}, 64'(b_out_valid), 64'(vld));
    chk({tag, ".out_sel"},   64'(b_out_sel),   64'(sel));
    chk({tag, ".out_data"},  64'(b_out_data),  64'(dat));
  endtask

  function automatic logic [W-1:0] a_word(input int i);
    return 32'hC0DE_0000 | W'(i);
  endfunction

  initial begin
    a_sclr = 1'b1; a_clken = 1'b1; a_out_ready = 1'b1; a_req_valid = '0;
    b_sclr = 1'b1; b_clken = 1'b1; b_out_ready = 1'b1; b_req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_req_data[i*W +: W] = a_word(i);
      b_req_data[i*W +: W] = 32'hB0B0_0000 | W'(i);
    end
    b_req_data[2*W +: W] = 32'hA5A5_0002;
`ifdef RR_MUX_ARB_LOCK_EN
    a_req_last = '1;
    b_req_last = '1;
`endif
    tick();
    tick();

    // Reset state
    a_sclr = 1'b0;
    #1;
    chk_a("reset", 1'b0, '0, '0);
    chk("reset.req_ready", 64'(a_req_ready), 64'd0);

    // All requesters valid: grants rotate 0,1,2,3,0,1; outputs trail by one cycle
    a_req_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr.req_ready", 64'(a_req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 1) chk_a("rr", 1'b1, WS'((c - 1) % 4), a_word((c - 1) % 4));
      else        chk("rr.first_out_valid", 64'(a_out_valid), 64'd0);
      tick();
    end

    // Backpressure: beat from requester 1 held, nothing granted
    a_out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall.req_ready", 64'(a_req_ready), 64'd0);
      chk_a("stall", 1'b1, 2'd1, a_word(1));
      tick();
    end
    a_out_ready = 1'b1;
    #1;
    chk("unstall.req_ready", 64'(a_req_ready), 64'(4'b0100));
    chk_a("unstall", 1'b1, 2'd1, a_word(1));
    tick();
    chk_a("after_stall", 1'b1, 2'd2, a_word(2));
    chk("after_stall.req_ready", 64'(a_req_ready), 64'(4'b1000));

    // Clock enable low: everything frozen, then sequence resumes
    a_clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("clken.req_ready", 64'(a_req_ready), 64'd0);
      chk_a("clken", 1'b1, 2'd2, a_word(2));
      tick();
    end
    a_clken = 1'b1;
    #1;
    chk("resume.req_ready", 64'(a_req_ready), 64'(4'b1000));
    tick();
    chk_a("resume", 1'b1, 2'd3, a_word(3));
    chk("resume2.req_ready", 64'(a_req_ready), 64'(4'b0001));
    tick();
    chk_a("resume2", 1'b1, 2'd0, a_word(0));

    // No requests: no grant, bubble reads zero, pointer held at 1
    a_req_valid = '0;
    #1;
    chk("idle.req_ready", 64'(a_req_ready), 64'd0);
    tick();
    chk_a("bubble", 1'b0, '0, '0);
    a_req_valid = 4'b1111;
    #1;
    chk("ptr_hold.req_ready", 64'(a_req_ready), 64'(4'b0010));
    a_req_valid = '0;
    tick();

    // Instance b: single requester 2, two-stage latency
    b_sclr = 1'b0;
    b_req_valid = 4'b0100;
    #1;
    chk("lat.req_ready", 64'(b_req_ready), 64'(4'b0100));
    chk("lat.out_valid0", 64'(b_out_valid), 64'd0);
    tick();
    b_req_valid = '0;
    #1;
    chk("lat.out_valid1", 64'(b_out_valid), 64'd0);
    tick();
    chk_b("lat", 1'b1, 2'd2, 32'hA5A5_0002);
    tick();
    chk_b("lat_after", 1'b0, '0, '0);

    // Clear with two beats in flight (requesters 3 then 0)
    b_req_valid = 4'b1111;
    tick();
    tick();
    chk_b("inflight", 1'b1, 2'd3, 32'hB0B0_0003);
    b_sclr = 1'b1;
    #1;
    chk("sclr.req_ready", 64'(b_req_ready), 64'd0);
    tick();
    b_sclr = 1'b0;
    b_req_valid = 4'b0110;
    #1;
    chk_b("sclr", 1'b0, '0, '0);
    chk("sclr_release.req_ready", 64'(b_req_ready), 64'(4'b0010));
    tick();
    b_req_valid = '0;
    #1;
    chk("sclr_discard.out_valid", 64'(b_out_valid), 64'd0);
    tick();
    chk_b("sclr_first", 1'b1, 2'd1, 32'hB0B0_0001);

`ifdef RR_MUX_ARB_LOCK_EN
    // Burst lock: requester 1 owns three beats while 0 and 3 wait
    a_sclr = 1'b1;
    tick();
    a_sclr = 1'b0;
    a_req_valid = 4'b0010;
    a_req_last = '0;
    #1;
    chk("lock.b1.req_ready", 64'(a_req_ready), 64'(4'b0010));
    tick();
    a_req_valid = 4'b1011;
    #1;
    chk("lock.b2.req_ready", 64'(a_req_ready), 64'(4'b0010));
    chk_a("lock.b1", 1'b1, 2'd1, a_word(1));
    tick();
    a_req_last = 4'b0010;
    #1;
    chk("lock.b3.req_ready", 64'(a_req_ready), 64'(4'b0010));
    chk_a("lock.b2", 1'b1, 2'd1, a_word(1));
    tick();
    a_req_last = '0;
    #1;
    chk("lock.next.req_ready", 64'(a_req_ready), 64'(4'b1000));
    chk_a("lock.b3", 1'b1, 2'd1, a_word(1));
    tick();
    a_req_valid = '0;
    chk_a("lock.next", 1'b1, 2'd3, a_word(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
